// File: rtl/axil_mem_arbiter_if.sv
// axil_mem_arbiter_if: AXI4-lite master bus used by axil_mem_arbiter.
//   master modport: the arbiter side (drives valid/addr/data, bready, rready).
//   slave  modport: the memory fabric side (drives readies, responses, rdata).
interface axil_mem_arbiter_if;
  // Write address channel
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  // Write data channel
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  // Write response channel
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  // Read address channel
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  // Read data channel
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axil_mem_arbiter.sv
// axil_mem_arbiter: shares one AXI4-lite master port between the instruction
// fetch path (read only) and the load/store data path. Round-robin on ties,
// one outstanding AXI transaction at a time.
//
// Ports:
//   clk, reset      clock (rising edge), synchronous active-low reset
//   i_req/i_addr    fetch request; i_ready pulse, i_rdata, i_err on completion
//   d_req/d_we/d_addr/d_wdata/d_wstrb
//                   data request; d_ready pulse, d_rdata, d_err on completion
//   m_axil          AXI4-lite master bus (axil_mem_arbiter_if.master)
//
// Optional feature: define ARB_TIMEOUT_EN to enable a slave-response watchdog
// that abandons a stalled transaction after TIMEOUT_CYCLES with err=1, rdata=0.
module axil_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_req,
  input  logic [31:0]        i_addr,
  output logic               i_ready,
  output logic [31:0]        i_rdata,
  output logic               i_err,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [31:0]        d_addr,
  input  logic [31:0]        d_wdata,
  input  logic [3:0]         d_wstrb,
  output logic               d_ready,
  output logic [31:0]        d_rdata,
  output logic               d_err,
  axil_mem_arbiter_if.master m_axil
);

  typedef enum logic [2:0] {
    StIdle, StRdAddr, StRdData, StWrReq, StWrResp, StDone
  } state_e;

  state_e      r_state;
  state_e      w_state_next;

  logic        r_grant;       // 1: data side owns the current transaction
  logic        r_last_grant;  // 1: data side was granted last
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [2:0]  r_prot;

  logic        r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready;
  logic        w_arvalid_d, w_rready_d, w_awvalid_d, w_wvalid_d, w_bready_d;

  logic [31:0] r_i_rdata, r_d_rdata;
  logic        r_i_err, r_d_err;

  logic        w_start;
  logic        w_grant_data;
  logic        w_aw_done;
  logic        w_w_done;
  logic        w_complete;
  logic        w_cpl_err;
  logic [31:0] w_cpl_rdata;
  logic        w_timeout;
  logic        w_unused_resp;

  assign w_start      = i_req | d_req;
  // Data wins when alone, or on a tie when fetch was granted last.
  assign w_grant_data = d_req & (~i_req | ~r_last_grant);
  // A write channel counts as done once its valid has dropped or is handshaking now.
  assign w_aw_done    = ~r_awvalid | m_axil.awready;
  assign w_w_done     = ~r_wvalid | m_axil.wready;

  // Only resp[1] distinguishes OKAY/EXOKAY from SLVERR/DECERR.
  assign w_unused_resp = m_axil.rresp[0] ^ m_axil.bresp[0];

`ifdef ARB_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;
  logic        w_busy;
  logic        w_progress;

  always_comb begin
    w_busy     = 1'b0;
    w_progress = 1'b0;
    unique case (r_state)
      StRdAddr: begin
        w_busy     = 1'b1;
        w_progress = m_axil.arready;
      end
      StRdData: begin
        w_busy     = 1'b1;
        w_progress = m_axil.rvalid;
      end
      StWrReq: begin
        w_busy     = 1'b1;
        w_progress = (r_awvalid & m_axil.awready) | (r_wvalid & m_axil.wready);
      end
      StWrResp: begin
        w_busy     = 1'b1;
        w_progress = m_axil.bvalid;
      end
      default: ;
    endcase
  end

  // Fires on the cycle the counter would reach the limit.
  assign w_timeout = w_busy & ~w_progress & (r_tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tmo_cnt <= '0;
    end else if (w_state_next != r_state) begin
      r_tmo_cnt <= '0;
    end else if (w_busy & ~w_progress) begin
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
  end
`else
  logic [15:0] w_unused_tmo;
  assign w_unused_tmo = 16'(TIMEOUT_CYCLES);
  assign w_timeout    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_start) w_state_next = (w_grant_data & d_we) ? StWrReq : StRdAddr;
      end
      StRdAddr: if (m_axil.arready) w_state_next = StRdData;
      StRdData: if (m_axil.rvalid)  w_state_next = StDone;
      StWrReq:  if (w_aw_done & w_w_done) w_state_next = StWrResp;
      StWrResp: if (m_axil.bvalid)  w_state_next = StDone;
      StDone:   w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
    if (w_timeout) w_state_next = StDone;
  end

  // Output logic: next values of the registered AXI valid/ready outputs
  always_comb begin
    w_arvalid_d = r_arvalid;
    w_rready_d  = r_rready;
    w_awvalid_d = r_awvalid;
    w_wvalid_d  = r_wvalid;
    w_bready_d  = r_bready;
    unique case (r_state)
      StIdle: begin
        if (w_start) begin
          if (w_grant_data & d_we) begin
            w_awvalid_d = 1'b1;
            w_wvalid_d  = 1'b1;
          end else begin
            w_arvalid_d = 1'b1;
          end
        end
      end
      StRdAddr: begin
        if (m_axil.arready) begin
          w_arvalid_d = 1'b0;
          w_rready_d  = 1'b1;
        end
      end
      StRdData: if (m_axil.rvalid) w_rready_d = 1'b0;
      StWrReq: begin
        if (m_axil.awready) w_awvalid_d = 1'b0;
        if (m_axil.wready)  w_wvalid_d  = 1'b0;
        if (w_aw_done & w_w_done) w_bready_d = 1'b1;
      end
      StWrResp: if (m_axil.bvalid) w_bready_d = 1'b0;
      default: ;
    endcase
    if (w_timeout) begin
      w_arvalid_d = 1'b0;
      w_rready_d  = 1'b0;
      w_awvalid_d = 1'b0;
      w_wvalid_d  = 1'b0;
      w_bready_d  = 1'b0;
    end
  end

  // Completion results are captured on the edge into StDone so they appear
  // together with the ready pulse.
  assign w_complete  = (w_state_next == StDone) & (r_state != StDone);
  assign w_cpl_err   = w_timeout |
                       ((r_state == StRdData) ? m_axil.rresp[1] : m_axil.bresp[1]);
  assign w_cpl_rdata = w_timeout ? 32'h0 : m_axil.rdata;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_prot       <= '0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
      r_i_err      <= 1'b0;
      r_d_err      <= 1'b0;
    end else begin
      r_arvalid <= w_arvalid_d;
      r_rready  <= w_rready_d;
      r_awvalid <= w_awvalid_d;
      r_wvalid  <= w_wvalid_d;
      r_bready  <= w_bready_d;
      if (r_state == StIdle && w_start) begin
        r_grant <= w_grant_data;
        r_we    <= w_grant_data & d_we;
        r_addr  <= w_grant_data ? d_addr : i_addr;
        r_prot  <= w_grant_data ? 3'b000 : 3'b101;
        if (w_grant_data & d_we) begin
          r_wdata <= d_wdata;
          r_wstrb <= d_wstrb;
        end
      end
      if (w_complete) begin
        if (r_grant) begin
          r_d_err <= w_cpl_err;
          if (!r_we) r_d_rdata <= w_cpl_rdata;
        end else begin
          r_i_err   <= w_cpl_err;
          r_i_rdata <= w_cpl_rdata;
        end
      end
      if (r_state == StDone) r_last_grant <= r_grant;
    end
  end

  assign i_ready = (r_state == StDone) & ~r_grant;
  assign d_ready = (r_state == StDone) & r_grant;
  assign i_rdata = r_i_rdata;
  assign i_err   = r_i_err;
  assign d_rdata = r_d_rdata;
  assign d_err   = r_d_err;

  assign m_axil.arvalid = r_arvalid;
  assign m_axil.araddr  = r_addr;
  assign m_axil.arprot  = r_prot;
  assign m_axil.rready  = r_rready;
  assign m_axil.awvalid = r_awvalid;
  assign m_axil.awaddr  = r_addr;
  assign m_axil.awprot  = r_prot;
  assign m_axil.wvalid  = r_wvalid;
  assign m_axil.wdata   = r_wdata;
  assign m_axil.wstrb   = r_wstrb;
  assign m_axil.bready  = r_bready;

endmodule

// File: tb/tb_axil_mem_arbiter.sv
// tb_axil_mem_arbiter: directed, table-driven bench for axil_mem_arbiter with a
// behavioural AXI4-lite slave whose per-channel ready delays are configurable.
module tb_axil_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        d_err;

  axil_mem_arbiter_if bus ();

  axil_mem_arbiter #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_ready (i_ready),
    .i_rdata (i_rdata),
    .i_err   (i_err),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_wstrb (d_wstrb),
    .d_ready (d_ready),
    .d_rdata (d_rdata),
    .d_err   (d_err),
    .m_axil  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Slave configuration and captured handshake values
  int          cfg_ar_dly, cfg_aw_dly, cfg_w_dly, cfg_r_dly;
  logic [31:0] cfg_rdata;
  logic [1:0]  cfg_resp;
  logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
  logic [2:0]  cap_arprot, cap_awprot;
  logic [3:0]  cap_wstrb;
  int          n_ar, n_aw, n_w;
  int          ar_cnt, aw_cnt, w_cnt, r_cnt;

  initial begin
    cfg_ar_dly = 0; cfg_aw_dly = 0; cfg_w_dly = 0; cfg_r_dly = 0;
    cfg_rdata = '0; cfg_resp = '0;
    n_ar = 0; n_aw = 0; n_w = 0;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0;
    bus.arready = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0;
    bus.rvalid = 1'b0; bus.bvalid = 1'b0;
    bus.rdata = '0; bus.rresp = '0; bus.bresp = '0;
  end

  // Behavioural slave, updated away from the active edge
  always @(negedge clk) begin
    if (bus.arvalid) begin
      bus.arready = (ar_cnt >= cfg_ar_dly);
      if (bus.arready) begin
        cap_araddr = bus.araddr; cap_arprot = bus.arprot; n_ar++;
      end
      ar_cnt++;
    end else begin
      bus.arready = 1'b0; ar_cnt = 0;
    end
    if (bus.awvalid) begin
      bus.awready = (aw_cnt >= cfg_aw_dly);
      if (bus.awready) begin
        cap_awaddr = bus.awaddr; cap_awprot = bus.awprot; n_aw++;
      end
      aw_cnt++;
    end else begin
      bus.awready = 1'b0; aw_cnt = 0;
    end
    if (bus.wvalid) begin
      bus.wready = (w_cnt >= cfg_w_dly);
      if (bus.wready) begin
        cap_wdata = bus.wdata; cap_wstrb = bus.wstrb; n_w++;
      end
      w_cnt++;
    end else begin
      bus.wready = 1'b0; w_cnt = 0;
    end
    if (bus.rready) begin
      bus.rvalid = (r_cnt >= cfg_r_dly);
      bus.rdata  = cfg_rdata;
      bus.rresp  = cfg_resp;
      r_cnt++;
    end else begin
      bus.rvalid = 1'b0; r_cnt = 0;
    end
    bus.bvalid = bus.bready;
    bus.bresp  = cfg_resp;
  end

  typedef struct {
    logic        is_data;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          ar_dly;
    int          aw_dly;
    int          w_dly;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [2:0]  exp_prot;
  } vec_t;

  logic [31:0] model_i_rdata, model_d_rdata;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; i_req = 1'b0; d_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_i_rdata = '0; model_d_rdata = '0;
  endtask

  task automatic run_vec(input string id, input vec_t v);
    int          lat;
    bit          seen;
    int          both;
    logic        got_data, got_err;
    logic [31:0] got_rdata;
    int          ar0, aw0, w0;
    cfg_ar_dly = v.ar_dly; cfg_aw_dly = v.aw_dly; cfg_w_dly = v.w_dly; cfg_r_dly = 0;
    cfg_rdata = v.rdata; cfg_resp = v.resp;
    ar0 = n_ar; aw0 = n_aw; w0 = n_w;
    got_data = 1'b0; got_err = 1'b0; got_rdata = '0;
    @(negedge clk);
    if (v.is_data) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_wstrb = v.wstrb;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    lat = 0; seen = 0; both = 0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (i_ready && d_ready) both++;
      if (i_ready || d_ready) begin
        seen      = 1;
        got_data  = d_ready;
        got_err   = d_ready ? d_err : i_err;
        got_rdata = d_ready ? d_rdata : i_rdata;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    check({id, "_ready_seen"}, 32'(seen), 32'd1);
    check({id, "_latency"}, lat, v.exp_lat);
    check({id, "_side"}, 32'(got_data), 32'(v.is_data));
    check({id, "_both_ready"}, both, 0);
    check({id, "_err"}, 32'(got_err), 32'(v.exp_err));
    if (!v.we) begin
      check({id, "_rdata"}, got_rdata, v.exp_rdata);
      check({id, "_araddr"}, cap_araddr, v.addr);
      check({id, "_arprot"}, 32'(cap_arprot), 32'(v.exp_prot));
      check({id, "_ar_count"}, n_ar - ar0, 1);
      if (v.is_data) model_d_rdata = v.exp_rdata;
      else           model_i_rdata = v.exp_rdata;
    end else begin
      check({id, "_awaddr"}, cap_awaddr, v.addr);
      check({id, "_awprot"}, 32'(cap_awprot), 32'(v.exp_prot));
      check({id, "_wdata"}, cap_wdata, v.wdata);
      check({id, "_wstrb"}, 32'(cap_wstrb), 32'(v.wstrb));
      check({id, "_aw_w_count"}, (n_aw - aw0) + (n_w - w0), 2);
    end
    check({id, "_i_rdata_held"}, i_rdata, model_i_rdata);
    check({id, "_d_rdata_held"}, d_rdata, model_d_rdata);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[7];

  initial begin
    vec_t fresh;
    int   npulse, last, cyc, both, pulses, ar_high;
    bit   seen;

    //            data we  addr          wdata         strb     ar aw w  rdata         resp  lat err exp_rdata  prot
    vecs[0] = '{1'b0, 1'b0, 32'h0000_1000, 32'h0,        4'b0000, 0, 0, 0, 32'hDEAD_BEEF, 2'b00, 3, 1'b0, 32'hDEAD_BEEF, 3'b101};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_2004, 32'h0,        4'b0000, 0, 0, 0, 32'h1234_5678, 2'b01, 3, 1'b0, 32'h1234_5678, 3'b000};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_2008, 32'h0,        4'b0000, 0, 0, 0, 32'hCAFE_F00D, 2'b11, 3, 1'b1, 32'hCAFE_F00D, 3'b000};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0100, 32'hA5A5_5A5A, 4'b0011, 0, 0, 2, 32'h0,        2'b10, 5, 1'b1, 32'h0,        3'b000};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0200, 32'h0BAD_F00D, 4'b1111, 0, 0, 0, 32'h0,        2'b00, 3, 1'b0, 32'h0,        3'b000};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_3000, 32'h0,        4'b0000, 3, 0, 0, 32'h7777_8888, 2'b10, 6, 1'b1, 32'h7777_8888, 3'b101};
    vecs[6] = '{1'b1, 1'b1, 32'h0000_0300, 32'h1357_9BDF, 4'b1100, 0, 2, 0, 32'h0,        2'b01, 5, 1'b0, 32'h0,        3'b000};

    reset = 1'b0; i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    model_i_rdata = '0; model_d_rdata = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_i_ready", 32'(i_ready), 0);
    check("rst_d_ready", 32'(d_ready), 0);
    check("rst_i_err", 32'(i_err), 0);
    check("rst_d_err", 32'(d_err), 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_valids", {27'h0, bus.arvalid, bus.awvalid, bus.wvalid, bus.bready, bus.rready}, 0);
    check("rst_araddr", bus.araddr, 0);
    check("rst_awaddr", bus.awaddr, 0);
    check("rst_wdata", bus.wdata, 0);
    check("rst_wstrb", 32'(bus.wstrb), 0);
    check("rst_prot", {26'h0, bus.arprot, bus.awprot}, 0);
    reset = 1'b1;

    for (int k = 0; k < 7; k++) run_vec($sformatf("vec%0d", k), vecs[k]);

    // Tie out of reset: data first, then alternating, 4-cycle issue interval
    do_reset();
    cfg_ar_dly = 0; cfg_aw_dly = 0; cfg_w_dly = 0; cfg_r_dly = 0;
    cfg_rdata = 32'h1111_0000; cfg_resp = 2'b00;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h0000_00A0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_00B0;
    npulse = 0; last = 0; cyc = 0; both = 0;
    while (npulse < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (i_ready && d_ready) both++;
      if (i_ready || d_ready) begin
        check($sformatf("tie%0d_side", npulse), 32'(d_ready), 32'((npulse % 2) == 0));
        check($sformatf("tie%0d_araddr", npulse), cap_araddr,
              ((npulse % 2) == 0) ? 32'h0000_00B0 : 32'h0000_00A0);
        check($sformatf("tie%0d_gap", npulse), cyc - last, (npulse == 0) ? 3 : 4);
        last = cyc;
        npulse++;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    check("tie_pulses", npulse, 4);
    check("tie_both_ready", both, 0);
    model_i_rdata = 32'h1111_0000; model_d_rdata = 32'h1111_0000;

    // Reset while waiting in RD_DATA
    cfg_r_dly = 100000;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h0000_00C0;
    cyc = 0;
    while (!bus.rready && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_mid_reached_rdata", 32'(bus.rready), 1);
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_arvalid", 32'(bus.arvalid), 0);
    check("rst_mid_rready", 32'(bus.rready), 0);
    check("rst_mid_ready", {30'h0, i_ready, d_ready}, 0);
    reset = 1'b1; i_req = 1'b0;
    model_i_rdata = '0; model_d_rdata = '0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (i_ready || d_ready) pulses++;
    end
    check("rst_mid_no_pulse", pulses, 0);
    check("rst_mid_i_rdata", i_rdata, 0);
    fresh = '{1'b0, 1'b0, 32'h0000_00C4, 32'h0, 4'b0000, 0, 0, 0, 32'h2468_ACE0, 2'b00,
              3, 1'b0, 32'h2468_ACE0, 3'b101};
    run_vec("after_rst", fresh);

    // Stalled slave: arready never asserted
    cfg_ar_dly = 100000; cfg_rdata = 32'h5555_5555; cfg_resp = 2'b00;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h0000_00E0;
`ifdef ARB_TIMEOUT_EN
    ar_high = 0; seen = 0; cyc = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.arvalid) ar_high++;
      if (i_ready) begin
        seen = 1;
        check("tmo_i_err", 32'(i_err), 1);
        check("tmo_i_rdata", i_rdata, 0);
      end
    end
    i_req = 1'b0;
    check("tmo_seen", 32'(seen), 1);
    check("tmo_latency", cyc, 9);
    check("tmo_arvalid_cycles", ar_high, 8);
    @(negedge clk);
    check("tmo_arvalid_low", 32'(bus.arvalid), 0);
`else
    ar_high = 0; pulses = 0;
    repeat (120) begin
      @(negedge clk);
      if (bus.arvalid) ar_high++;
      if (i_ready || d_ready) pulses++;
    end
    check("stall_arvalid_cycles", ar_high, 120);
    check("stall_no_pulse", pulses, 0);
    check("stall_araddr", bus.araddr, 32'h0000_00E0);
    do_reset();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_mem_arbiter.md
# axil_mem_arbiter

Two-port arbiter that shares the core's single AXI4-lite master port between the instruction-fetch path and the load/store data path. It sits between the CPU state machine and the memory fabric. It accepts one request at a time from each side over a simple req/ready handshake and arbitrates round-robin on contention. It sequences the AXI4-lite read or write channel handshakes and returns data plus an error flag to the winning requester.

## Interface
- TIMEOUT_CYCLES, 256: slave-response watchdog limit; used only with ARB_TIMEOUT_EN.
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-low.
- i_req  in  1  fetch request; held with i_addr stable until i_ready.
- i_addr  in  32  fetch address.
- i_ready  out  1  one-cycle completion pulse to fetch side.
- i_rdata  out  32  fetched word; valid with i_ready, held until next fetch completion.
- i_err  out  1  fetch error; valid with i_ready.
- d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_wstrb stable until d_ready.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_wstrb  in  4  byte strobes.
- d_ready  out  1  one-cycle completion pulse to data side.
- d_rdata  out  32  load word; valid with d_ready, held until next data read completion.
- d_err  out  1  data error; valid with d_ready.
- awvalid/awready/awaddr[32]/awprot[3]: AXI write address (awready in).
- wvalid/wready/wdata[32]/wstrb[4]: AXI write data (wready in).
- bvalid  in  1, bready  out  1, bresp  in  2: AXI write response.
- arvalid/arready/araddr[32]/arprot[3]: AXI read address (arready in).
- rvalid  in  1, rready  out  1, rdata  in  32, rresp  in  2: AXI read data.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE: evaluates i_req and d_req. With one pending, grants it. With both pending, grants the side not granted last. last_grant resets to fetch, so data wins the first tie. Latches address, wdata, wstrb, and direction. Fetch is always a read.
- Prot: fetch 3'b101, data 3'b000.
- RD_ADDR: arvalid=1 until arready, then RD_DATA.
- RD_DATA: rready=1 until rvalid, then latches rdata and the error flag, then DONE.
- WR_REQ: awvalid and wvalid are asserted together, and each drops independently on its own handshake. Leaves for WR_RESP once both have completed, including when both complete in the same cycle.
- WR_RESP: bready=1 until bvalid, then latches the error flag, then DONE.
- Error flag = resp[1]. OKAY (00) and EXOKAY (01) give err=0. SLVERR (10) and DECERR (11) give err=1. Read data is forwarded even on error.
- DONE: pulses the granted side's ready for one cycle and updates last_grant, then IDLE. The ungranted side's outputs are unchanged.
- Requester dropping req mid-transaction: the transaction completes and the ready pulse is still issued.
- No new grant while not in IDLE. At most one outstanding AXI transaction.

## Timing
- Reset values: all valid/ready outputs 0, i_ready=d_ready=0, i_err=d_err=0, i_rdata=d_rdata=0, addresses/wdata 0, wstrb 0, awprot=arprot=3'b000, state IDLE.
- Reset mid-transaction: next edge forces the reset values, no ready pulse is issued, and the AXI transaction is abandoned.
- Zero-wait read: req sampled in cycle N; arvalid in N+1; rready in N+2; ready pulse in N+3.
- Zero-wait write: req sampled in N; awvalid and wvalid in N+1; bready in N+2; ready pulse in N+3.
- Back-to-back: a req held through the DONE cycle is re-evaluated in IDLE the cycle after DONE. Minimum issue interval is 4 cycles.
- AXI outputs are registered and stay stable while valid=1 and ready=0.

## Configuration
- ARB_TIMEOUT_EN defined:
  - An 16-bit counter clears on entry to any non-IDLE state and increments each cycle the awaited handshake is absent.
  - When it reaches TIMEOUT_CYCLES, all AXI valid/ready outputs drop, the state goes to DONE, err=1 is reported, and rdata reads 0.
- ARB_TIMEOUT_EN undefined: no counter; the block waits indefinitely on the slave.

## Test plan
- Fetch only, zero-wait slave, rdata=32'hDEADBEEF, rresp=00: i_ready high 3 cycles after req, i_rdata=32'hDEADBEEF, i_err=0, arprot=101.
- Simultaneous i_req and d_req (read) out of reset, repeated: data is granted first, then fetch, alternating; araddr matches the granted address each time, and d_ready/i_ready never pulse together.
- Data write: d_wstrb=4'b0011 to 32'h100; awready 2 cycles before wready; bresp=10. Expect wstrb=0011, awaddr=32'h100, one d_ready pulse with d_err=1, awprot=000.
- Read with rresp=01: err=0. Read with rresp=11: err=1 and rdata still forwarded.
- Reset asserted while in RD_DATA: next cycle arvalid=rready=0, state IDLE, no ready pulse; a fresh request afterwards completes normally.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8 and arready held 0: after 8 cycles arvalid drops and i_ready pulses with i_err=1 and i_rdata=0. Without the macro, arvalid stays high for 100+ cycles.
